// File: rtl/multicycle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_sequencer                                         |
// | Description : Control FSM for a multi-cycle RV64I datapath sharing one     |
// |               memory port between fetch and data access. Optional macro    |
// |               ILLEGAL_TRAP_EN halts on unknown opcodes (else NOP retire).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_sel,
  output logic [2:0]       state,
  output logic             mem_err,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] c_ST_FETCH  = 3'd0;
  localparam logic [2:0] c_ST_DECODE = 3'd1;
  localparam logic [2:0] c_ST_EXEC   = 3'd2;
  localparam logic [2:0] c_ST_MEM    = 3'd3;
  localparam logic [2:0] c_ST_WB     = 3'd4;
  localparam logic [2:0] c_ST_HALT   = 3'd7;

  localparam logic [2:0] c_CL_R   = 3'd0;
  localparam logic [2:0] c_CL_I   = 3'd1;
  localparam logic [2:0] c_CL_LD  = 3'd2;
  localparam logic [2:0] c_CL_SD  = 3'd3;
  localparam logic [2:0] c_CL_BR  = 3'd4;
  localparam logic [2:0] c_CL_ILL = 3'd5;

  localparam logic [6:0] c_OP_R  = 7'b0110011;
  localparam logic [6:0] c_OP_I  = 7'b0010011;
  localparam logic [6:0] c_OP_LD = 7'b0000011;
  localparam logic [6:0] c_OP_SD = 7'b0100011;
  localparam logic [6:0] c_OP_BR = 7'b1100011;

  // Fault fires on the wait cycle that would bring the counter to MEM_TIMEOUT.
  localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [2:0]       r_class;
  logic [2:0]       w_class;
  logic [7:0]       r_wait;
  logic             w_mem_phase;
  logic             w_timeout;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_retired;

  always_comb begin
    w_class = c_CL_ILL;
    case (opcode)
      c_OP_R:  w_class = c_CL_R;
      c_OP_I:  w_class = c_CL_I;
      c_OP_LD: w_class = c_CL_LD;
      c_OP_SD: w_class = c_CL_SD;
      c_OP_BR: w_class = c_CL_BR;
      default: w_class = c_CL_ILL;
    endcase
  end

  assign w_mem_phase = (r_state == c_ST_FETCH) || (r_state == c_ST_MEM);
  assign w_timeout   = w_mem_phase && !mem_ready && (r_wait == c_WAIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = c_ST_FETCH;
    case (r_state)
      c_ST_FETCH: begin
        if (mem_ready)      w_next_state = c_ST_DECODE;
        else if (w_timeout) w_next_state = c_ST_HALT;
        else                w_next_state = c_ST_FETCH;
      end
      c_ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        w_next_state = (w_class == c_CL_ILL) ? c_ST_HALT : c_ST_EXEC;
`else
        w_next_state = c_ST_EXEC;
`endif
      end
      c_ST_EXEC: begin
        case (r_class)
          c_CL_R, c_CL_I:   w_next_state = c_ST_WB;
          c_CL_LD, c_CL_SD: w_next_state = c_ST_MEM;
          default:          w_next_state = c_ST_FETCH;
        endcase
      end
      c_ST_MEM: begin
        if (mem_ready)      w_next_state = (r_class == c_CL_LD) ? c_ST_WB : c_ST_FETCH;
        else if (w_timeout) w_next_state = c_ST_HALT;
        else                w_next_state = c_ST_MEM;
      end
      c_ST_WB:   w_next_state = c_ST_FETCH;
      c_ST_HALT: w_next_state = c_ST_HALT;
      default:   w_next_state = c_ST_FETCH;
    endcase
  end

  // Output logic; gating with rst_n kills any in-flight write during reset.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_sel    = 1'b0;
    if (rst_n) begin
      case (r_state)
        c_ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        c_ST_EXEC: begin
          case (r_class)
            c_CL_BR: begin
              pc_write = 1'b1;
              pc_src   = zero;
            end
            c_CL_ILL: pc_write = 1'b1;
            default:  pc_write = 1'b0;
          endcase
        end
        c_ST_MEM: begin
          mem_sel = 1'b1;
          if (r_class == c_CL_SD) begin
            mem_write = 1'b1;
            pc_write  = mem_ready;
          end else begin
            mem_read = 1'b1;
          end
        end
        c_ST_WB: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          mem_to_reg = (r_class == c_CL_LD);
        end
        default: pc_write = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class <= c_CL_R;
    end else if (r_state == c_ST_DECODE) begin
      r_class <= w_class;
    end
  end

  // Wait counter restarts on every state change, so it is clear on entry to FETCH/MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= 8'd0;
    end else if (w_next_state != r_state) begin
      r_wait <= 8'd0;
    end else if (w_mem_phase && !mem_ready) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_err <= 1'b0;
    end else if (w_timeout) begin
      r_mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (pc_write) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if ((r_state == c_ST_DECODE) && (w_class == c_CL_ILL)) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign state   = r_state;
  assign mem_err = r_mem_err;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

The multicycle sequencer is the control FSM that converts the single-cycle RV64I datapath into a multi-cycle machine. It shares one memory port between instruction fetch and data access. The FSM steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the write enables for the PC, IR, register file and memory. A `mem_ready` handshake lets it tolerate variable-latency memory, and it counts retired instructions.

## Interface
- `MEM_TIMEOUT`, 15: maximum cycles to wait for `mem_ready` before faulting (range 1–255).
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `opcode` input 7: IR[6:0]; sampled only in DECODE.
- `zero` input 1: ALU zero flag; sampled only in EXEC.
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `pc_write` output 1: load PC this cycle; this is the retire strobe.
- `pc_src` output 1: 0 selects PC+4, 1 selects PC+imm; meaningful only when `pc_write`=1.
- `ir_write` output 1: capture memory read data into IR.
- `reg_write` output 1: register file write enable.
- `mem_to_reg` output 1: writeback source; 1 selects memory data, 0 selects the ALU result.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `mem_sel` output 1: memory address source; 0 selects PC (fetch), 1 selects the ALU result (data).
- `state` output 3: current state encoding, for debug.
- `mem_err` output 1: sticky memory-timeout fault.
- `illegal` output 1: sticky unknown-opcode flag.
- `retired` output CNT_W: count of retired instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. All other codes return to FETCH on the next edge.
- FETCH: assert `mem_read`=1 with `mem_sel`=0.
  - On `mem_ready`=1, assert `ir_write`=1 in the same cycle and go to DECODE.
- DECODE: classify `opcode` and latch the class into an internal register.
  - 0110011 → R.
  - 0010011 → I.
  - 0000011 → LD.
  - 0100011 → SD.
  - 1100011 → BR.
  - Any other value → ILL.
  - Go to EXEC, except ILL, which is handled as described under Configuration.
- EXEC, by latched class:
  - R or I: go to WB.
  - LD or SD: go to MEM.
  - BR: assert `pc_write`=1 with `pc_src`=`zero`, then go to FETCH.
- MEM, with `mem_sel`=1:
  - LD: assert `mem_read`; on `mem_ready`, go to WB.
  - SD: assert `mem_write`; on `mem_ready`, assert `pc_write`=1 with `pc_src`=0 and go to FETCH.
- WB: assert `reg_write`=1 and `pc_write`=1 with `pc_src`=0.
  - `mem_to_reg`=1 when the class is LD, else 0.
  - Go to FETCH.
- HALT: all strobes are 0. HALT is left only by reset.
- Wait counter:
  - An 8-bit counter clears on entry to FETCH or MEM and increments each cycle `mem_ready`=0.
  - When the counter reaches `MEM_TIMEOUT` with `mem_ready` still 0, set `mem_err`=1 and go to HALT.
- `retired` increments by 1 on every cycle with `pc_write`=1 and wraps modulo 2^CNT_W.
- Only one strobe group is active per state. `mem_read` and `mem_write` are never asserted together.

## Timing
- All strobes are combinational from `state`, the latched class, `zero` and `mem_ready`. `state` and the counters are registered.
- Reset values:
  - `state`=FETCH(0).
  - `mem_err`=0, `illegal`=0, `retired`=0.
  - All strobes are forced to 0 combinationally while `rst_n`=0.
- Reset asserted mid-instruction aborts the instruction immediately; no partial write completes after assertion.
- The first FETCH request occurs in the first cycle after `rst_n` rises.
- Latency with zero-wait memory, counted from the FETCH cycle to the retire cycle:
  - BR: 3 cycles.
  - R, I and SD: 4 cycles.
  - LD: 5 cycles.
  - Each wait cycle of `mem_ready` adds 1 cycle.
- `mem_ready` asserted outside FETCH and MEM is ignored.
- If `mem_ready` rises in the same cycle the timeout is reached, `mem_ready` wins and no fault is raised.

## Configuration
- `ILLEGAL_TRAP_EN`, defined: an ILL opcode sets `illegal`=1 and the FSM goes from DECODE to HALT. There is no retire.
- `ILLEGAL_TRAP_EN`, undefined: an ILL opcode is executed as a NOP.
  - DECODE goes to EXEC, and EXEC asserts `pc_write`=1 with `pc_src`=0, then goes to FETCH.
  - The instruction is retired. `illegal` stays 0.

## Test plan
- R-type, zero-wait: release reset and hold `mem_ready`=1 with opcode 0110011 → `state` sequence 0,1,2,4,0. `reg_write`=1 only in WB. `retired` goes 0→1 in cycle 4.
- LD with 2 wait cycles in MEM → `state` sequence 0,1,2,3,3,3,4. `mem_read` is held for 3 cycles with `mem_sel`=1. In WB, `mem_to_reg`=1.
- BEQ: with `zero`=1 → `pc_write`=1 and `pc_src`=1 in EXEC. With `zero`=0 → `pc_src`=0. Both cases take 3 cycles.
- Timeout: `MEM_TIMEOUT`=4, hold `mem_ready`=0 in FETCH → `mem_err`=1 and `state`=7 after 4 cycles. Strobes stay 0 afterwards until reset.
- Opcode 1111111: with `ILLEGAL_TRAP_EN` → `illegal`=1, `state`=7, `retired` unchanged. Without it → NOP retire in 3 cycles.
- Reset mid-SD (assert `rst_n`=0 in MEM) → `mem_write` drops in the same cycle and `retired`=0. After release, fetch restarts.
